hearts_hud_drawer: RTL and testbench
====================================

Name: hearts_hud_drawer

Overview:
- Upstream drawing stage that renders the player's remaining lives as a row of hearts in the top-left HUD area.
- Produces the heart drawing request and heart colour consumed by the display priority mux (priority 3, below end screen and player).
- Blinks the heart just lost for a fixed number of frames using a frame-counted state machine.
- Lives count is latched once per frame so the row never tears mid-frame.

Parameters:
- MAX_LIVES, 5, number of heart slots; livesIn values above this are clamped.
- HUD_X, 16, left pixel column of slot 0.
- HUD_Y, 8, top pixel row of the heart row.
- HEART_SIZE, 16, heart bitmap width and height in pixels; fixed at 16.
- HEART_GAP, 4, horizontal gap in pixels between slots.
- HEART_COLOR, 8'hE0, RGB332 colour of filled hearts.
- BLINK_FRAMES, 60, blink duration in frames.
- BLINK_PERIOD, 8, frames per blink phase (on or off).

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- livesIn  in  4  current lives count from game logic
- lifeLost  in  1  one-cycle pulse when a life is lost
- heartDrawingRequest  out  1  pixel belongs to a drawn heart
- heartRGB  out  8  colour for that pixel

Behaviour:
- Reset (asynchronous, active-low): heartDrawingRequest=0, heartRGB=8'h00, livesLatched=0, FSM=IDLE, frameCnt=0, blinkIdx=0.
- Latching:
  - On startOfFrame, livesLatched <= min(livesIn, MAX_LIVES).
  - livesLatched holds for the rest of the frame.
- Slot geometry:
  - Slot i occupies x in [HUD_X + i*(HEART_SIZE+HEART_GAP), +HEART_SIZE), y in [HUD_Y, HUD_Y+HEART_SIZE).
  - Local offsets (x,y) are 4 bits each and index a constant 16x16 heart mask.
  - Gap pixels and pixels outside the row are never drawn.
- Heart visibility:
  - IDLE: filled heart i is visible iff i < livesLatched.
  - BLINK: slot blinkIdx is visible iff (frameCnt / BLINK_PERIOD) is even, regardless of livesLatched.
  - BLINK: all other slots follow the IDLE rule.
- FSM:
  - IDLE -> BLINK on lifeLost when livesLatched > 0. Sets blinkIdx <= livesLatched-1 and frameCnt <= 0.
  - lifeLost while livesLatched == 0 is ignored.
  - BLINK: frameCnt increments on each startOfFrame.
  - BLINK -> IDLE on the startOfFrame where frameCnt == BLINK_FRAMES-1; frameCnt returns to 0.
  - lifeLost while in BLINK restarts the blink: blinkIdx is recomputed from the current livesLatched and frameCnt <= 0.
  - lifeLost and startOfFrame in the same cycle: lifeLost uses the pre-update livesLatched; frameCnt is set to 0, not incremented.
- Output (registered, latency exactly 1 clk from pixelX/pixelY):
  - Mask bit set and heart visible: request=1, RGB=HEART_COLOR.
  - Otherwise: request=0, RGB=8'h00.
- Width rules:
  - Slot index is computed by comparison against constant slot boundaries; no division.
  - frameCnt is wide enough for BLINK_FRAMES-1 and saturates defensively.
- Reset mid-blink returns to IDLE with no hearts until the next startOfFrame.

Optional Feature:
- Macro: HEARTS_HUD_OUTLINE_EN.
- Defined:
  - Slots with livesLatched <= i < MAX_LIVES draw an empty-heart outline (constant 16x16 outline mask) in 8'h92.
  - A blinking slot in its off phase also shows the outline.
  - Filled hearts take precedence over outlines.
- Undefined: empty slots draw nothing; no outline mask logic is synthesized.

Test Plan:
- Reset asserted mid-frame -> request=0 and RGB=8'h00 immediately; no hearts drawn until the first startOfFrame after release.
- livesIn=3, startOfFrame, scan row HUD_Y+8 -> request=1 with RGB=8'hE0 only inside the masks of slots 0-2; slots 3-4 and gaps give 0; response lags pixelX by 1 clk.
- livesIn=9 -> exactly 5 hearts drawn (clamp).
- livesLatched=3, lifeLost pulse, livesIn=2 next frame -> slot 2 visible on frames 0-7, hidden on 8-15, visible on 16-23, and so on. After 60 frames slot 2 stays hidden and the FSM is IDLE.
- Second lifeLost at blink frame 20 (livesLatched=2) -> blinkIdx=1, frameCnt restarts at 0, slot 2 no longer drawn.
- lifeLost with livesLatched=0 -> FSM stays IDLE, no hearts.
- With HEARTS_HUD_OUTLINE_EN, livesIn=1 -> slot 0 filled 8'hE0; slots 1-4 outline pixels at 8'h92.

Source files
------------

// File: rtl/hearts_hud_drawer.sv
// HUD lives row: draws up to MAX_LIVES hearts top-left and blinks the heart just lost.
// Optional empty-heart outlines are enabled with `define HEARTS_HUD_OUTLINE_EN.
module hearts_hud_drawer #(
    parameter int unsigned MAX_LIVES    = 5,
    parameter int unsigned HUD_X        = 16,
    parameter int unsigned HUD_Y        = 8,
    parameter int unsigned HEART_SIZE   = 16,
    parameter int unsigned HEART_GAP    = 4,
    parameter logic [7:0]  HEART_COLOR  = 8'hE0,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [3:0]  livesIn,
    input  logic        lifeLost,
    output logic        heartDrawingRequest,
    output logic [7:0]  heartRGB
);

    localparam int unsigned LvW    = $clog2(MAX_LIVES + 1);
    localparam int unsigned FcW    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned PhW    = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam int unsigned Stride = HEART_SIZE + HEART_GAP;

    localparam logic [3:0]     MaxLivesIn = 4'(MAX_LIVES);
    localparam logic [LvW-1:0] MaxLives   = LvW'(MAX_LIVES);
    localparam logic [FcW-1:0] FrameLast  = FcW'(BLINK_FRAMES - 1);
    localparam logic [PhW-1:0] PhaseLast  = PhW'(BLINK_PERIOD - 1);
    localparam logic [10:0]    RowTop     = 11'(HUD_Y);
    localparam logic [10:0]    RowBot     = 11'(HUD_Y + HEART_SIZE);
    localparam logic [10:0]    SlotW      = 11'(HEART_SIZE);

    typedef enum logic [0:0] {StIdle, StBlink} state_e;

    state_e         state_q, state_d;
    logic [LvW-1:0] lives_q, lives_d;
    logic [LvW-1:0] blink_idx_q, blink_idx_d;
    logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
    logic [PhW-1:0] phase_cnt_q, phase_cnt_d;
    logic           blink_off_q, blink_off_d;
    logic           req_q, req_d;
    logic [7:0]     rgb_q, rgb_d;

    logic [3:0]  lx;
    logic [3:0]  ly;
    logic [10:0] slot_lo;
    logic        vis;
    logic        hit_fill;
    logic [15:0] heart_bits;

    // Row y of the heart bitmap; bit 15 is the leftmost pixel.
    function automatic logic [15:0] heart_row(input logic [3:0] y);
        case (y)
            4'd1:    heart_row = 16'b0011100000011100;
            4'd2:    heart_row = 16'b0111110000111110;
            4'd3:    heart_row = 16'b1111111001111111;
            4'd4:    heart_row = 16'b1111111111111111;
            4'd5:    heart_row = 16'b1111111111111111;
            4'd6:    heart_row = 16'b1111111111111111;
            4'd7:    heart_row = 16'b0111111111111110;
            4'd8:    heart_row = 16'b0111111111111110;
            4'd9:    heart_row = 16'b0011111111111100;
            4'd10:   heart_row = 16'b0001111111111000;
            4'd11:   heart_row = 16'b0000111111110000;
            4'd12:   heart_row = 16'b0000011111100000;
            4'd13:   heart_row = 16'b0000001111000000;
            4'd14:   heart_row = 16'b0000000110000000;
            default: heart_row = 16'b0000000000000000;
        endcase
    endfunction

`ifdef HEARTS_HUD_OUTLINE_EN
    localparam logic [7:0] OutlineColor = 8'h92;

    logic        hit_outline;
    logic [15:0] outline_bits;

    function automatic logic [15:0] outline_row(input logic [3:0] y);
        case (y)
            4'd1:    outline_row = 16'b0011100000011100;
            4'd2:    outline_row = 16'b0100010000100010;
            4'd3:    outline_row = 16'b1000001001000001;
            4'd4:    outline_row = 16'b1000000110000001;
            4'd5:    outline_row = 16'b1000000000000001;
            4'd6:    outline_row = 16'b1000000000000001;
            4'd7:    outline_row = 16'b0100000000000010;
            4'd8:    outline_row = 16'b0100000000000010;
            4'd9:    outline_row = 16'b0010000000000100;
            4'd10:   outline_row = 16'b0001000000001000;
            4'd11:   outline_row = 16'b0000100000010000;
            4'd12:   outline_row = 16'b0000010000100000;
            4'd13:   outline_row = 16'b0000001001000000;
            4'd14:   outline_row = 16'b0000000110000000;
            default: outline_row = 16'b0000000000000000;
        endcase
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        blink_idx_d = blink_idx_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        blink_off_d = blink_off_q;

        if (startOfFrame) begin
            lives_d = (livesIn > MaxLivesIn) ? MaxLives : LvW'(livesIn);
        end

        // lifeLost looks at the pre-update count and wins over a same-cycle frame tick.
        if (lifeLost && (lives_q != '0)) begin
            state_d     = StBlink;
            blink_idx_d = lives_q - LvW'(1);
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if ((state_q == StBlink) && startOfFrame) begin
            if (frame_cnt_q == FrameLast) begin
                state_d     = StIdle;
                frame_cnt_d = '0;
                phase_cnt_d = '0;
                blink_off_d = 1'b0;
            end else begin
                if (frame_cnt_q != '1) begin
                    frame_cnt_d = frame_cnt_q + FcW'(1);
                end
                // Phase counter tracks frameCnt / BLINK_PERIOD parity without a divider.
                if (phase_cnt_q == PhaseLast) begin
                    phase_cnt_d = '0;
                    blink_off_d = ~blink_off_q;
                end else begin
                    phase_cnt_d = phase_cnt_q + PhW'(1);
                end
            end
        end
    end

    always_comb begin
        hit_fill   = 1'b0;
        lx         = '0;
        slot_lo    = '0;
        vis        = 1'b0;
        ly         = 4'(pixelY - RowTop);
        heart_bits = heart_row(ly);
`ifdef HEARTS_HUD_OUTLINE_EN
        hit_outline  = 1'b0;
        outline_bits = outline_row(ly);
`endif
        if ((pixelY >= RowTop) && (pixelY < RowBot)) begin
            for (int i = 0; i < int'(MAX_LIVES); i++) begin
                slot_lo = 11'(HUD_X + i * Stride);
                if ((pixelX >= slot_lo) && (pixelX < slot_lo + SlotW)) begin
                    lx  = 4'(pixelX - slot_lo);
                    vis = (LvW'(i) < lives_q);
                    if ((state_q == StBlink) && (blink_idx_q == LvW'(i))) begin
                        vis = ~blink_off_q;
                    end
                    if (vis && heart_bits[4'd15 - lx]) begin
                        hit_fill = 1'b1;
                    end
`ifdef HEARTS_HUD_OUTLINE_EN
                    if (!vis && outline_bits[4'd15 - lx]) begin
                        hit_outline = 1'b1;
                    end
`endif
                end
            end
        end

`ifdef HEARTS_HUD_OUTLINE_EN
        req_d = hit_fill | hit_outline;
        rgb_d = hit_fill ? HEART_COLOR : (hit_outline ? OutlineColor : 8'h00);
`else
        req_d = hit_fill;
        rgb_d = hit_fill ? HEART_COLOR : 8'h00;
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            lives_q     <= '0;
            blink_idx_q <= '0;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            blink_off_q <= 1'b0;
            req_q       <= 1'b0;
            rgb_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            blink_idx_q <= blink_idx_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            blink_off_q <= blink_off_d;
            req_q       <= req_d;
            rgb_q       <= rgb_d;
        end
    end

    assign heartDrawingRequest = req_q;
    assign heartRGB            = rgb_q;

endmodule

// File: tb/tb_hearts_hud_drawer.sv
// Bench for hearts_hud_drawer: frame-level model of the lives row compared every cycle,
// plus hand-computed probes at known pixels.
module tb_hearts_hud_drawer;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        lifeLost = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic [3:0]  livesIn = '0;
    logic        heartDrawingRequest;
    logic [7:0]  heartRGB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hearts_hud_drawer dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .pixelX              (pixelX),
        .pixelY              (pixelY),
        .livesIn             (livesIn),
        .lifeLost            (lifeLost),
        .heartDrawingRequest (heartDrawingRequest),
        .heartRGB            (heartRGB)
    );

    string heart [16] = '{
        "................",
        "..###......###..",
        ".#####....#####.",
        "#######..#######",
        "################",
        "################",
        "################",
        ".##############.",
        ".##############.",
        "..############..",
        "...##########...",
        "....########....",
        ".....######.....",
        "......####......",
        ".......##.......",
        "................"
    };

    // Model state: what the game has told us, counted in whole frames.
    int         m_lives = 0;
    bit         m_blink = 1'b0;
    int         m_idx = 0;
    int         m_frames = 0;
    int         m_next_lives = 0;
    logic [8:0] m_exp = '0;

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got req=%0b rgb=%02h, expected req=%0b rgb=%02h",
                     name, $time, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic bit m_visible(input int slot);
        if (m_blink && slot == m_idx) return ((m_frames / 8) % 2) == 0;
        return slot < m_lives;
    endfunction

    function automatic logic [8:0] m_pixel(input int x, input int y);
        int  rel, slot, off;
        byte ch;
        if (y < 8 || y >= 24 || x < 16) return 9'h000;
        rel  = x - 16;
        slot = rel / 20;
        off  = rel % 20;
        if (slot >= 5 || off >= 16) return 9'h000;
        ch = heart[y - 8][off];
        if (ch != "#") return 9'h000;
        return m_visible(slot) ? 9'h1E0 : 9'h000;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lives  = 0;
            m_blink  = 1'b0;
            m_idx    = 0;
            m_frames = 0;
            m_exp    = 9'h000;
        end else begin
            m_exp = m_pixel(int'(pixelX), int'(pixelY));
            m_next_lives = startOfFrame ? ((livesIn > 4'd5) ? 5 : int'(livesIn)) : m_lives;
            if (lifeLost && m_lives > 0) begin
                m_blink  = 1'b1;
                m_idx    = m_lives - 1;
                m_frames = 0;
            end else if (m_blink && startOfFrame) begin
                m_frames++;
                if (m_frames >= 60) begin
                    m_blink  = 1'b0;
                    m_frames = 0;
                end
            end
            m_lives = m_next_lives;
        end
    end

    always @(negedge clk) begin
        chk("pixel", {heartDrawingRequest, heartRGB}, m_exp);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sof_pulse();
        pixelY = 11'd0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic lost_pulse();
        lifeLost = 1'b1;
        tick();
        lifeLost = 1'b0;
    endtask

    task automatic scan_row();
        for (int x = 12; x <= 120; x++) begin
            pixelX = 11'(x);
            pixelY = 11'd16;
            tick();
        end
    endtask

    task automatic probe(input int x, input bit on, input string name);
        pixelX = 11'(x);
        pixelY = 11'd16;
        @(posedge clk);
        #1;
        chk(name, {heartDrawingRequest, heartRGB}, on ? 9'h1E0 : 9'h000);
        @(negedge clk);
    endtask

    initial begin
        #3 resetN = 1'b0;
        livesIn = 4'd3;
        tick();
        chk("reset_state", {heartDrawingRequest, heartRGB}, 9'h000);
        tick();
        tick();
        resetN = 1'b1;

        // No frame start yet: nothing latched.
        scan_row();
        probe(24, 1'b0, "no_sof_yet");

        // Three lives; slots at x = 16, 36, 56, 76, 96.
        sof_pulse();
        scan_row();
        probe(24, 1'b1, "l3_slot0");
        probe(16, 1'b0, "l3_mask_edge");
        probe(33, 1'b0, "l3_gap");
        probe(64, 1'b1, "l3_slot2");
        probe(84, 1'b0, "l3_slot3");

        pixelX = 11'd24;
        pixelY = 11'd16;
        @(posedge clk);
        #1;
        chk("lat_new", {heartDrawingRequest, heartRGB}, 9'h1E0);
        pixelX = 11'd33;
        #1;
        chk("lat_hold", {heartDrawingRequest, heartRGB}, 9'h1E0);
        @(posedge clk);
        #1;
        chk("lat_next", {heartDrawingRequest, heartRGB}, 9'h000);
        @(negedge clk);

        livesIn = 4'd9;
        sof_pulse();
        scan_row();
        probe(104, 1'b1, "clamp_slot4");
        probe(124, 1'b0, "clamp_past_row");

        // Lose the third heart and watch it blink for 60 frames.
        livesIn = 4'd3;
        sof_pulse();
        lost_pulse();
        livesIn = 4'd2;
        probe(64, 1'b1, "blink_f0");
        for (int f = 1; f <= 62; f++) begin
            sof_pulse();
            scan_row();
            case (f)
                7:  probe(64, 1'b1, "blink_f7");
                8:  probe(64, 1'b0, "blink_f8");
                16: probe(64, 1'b1, "blink_f16");
                55: probe(64, 1'b1, "blink_f55");
                56: probe(64, 1'b0, "blink_f56");
                60: probe(64, 1'b0, "blink_done");
                62: probe(44, 1'b1, "idle_slot1");
                default: ;
            endcase
        end

        // Second loss at blink frame 20 moves the blink to slot 1.
        livesIn = 4'd3;
        sof_pulse();
        lost_pulse();
        livesIn = 4'd2;
        for (int f = 1; f <= 20; f++) begin
            sof_pulse();
            scan_row();
        end
        probe(64, 1'b1, "relost_f20");
        lost_pulse();
        probe(64, 1'b0, "relost_slot2_gone");
        probe(44, 1'b1, "relost_slot1_on");
        livesIn = 4'd1;
        for (int f = 1; f <= 8; f++) begin
            sof_pulse();
            scan_row();
        end
        probe(44, 1'b0, "relost_slot1_off");
        for (int f = 1; f <= 55; f++) begin
            sof_pulse();
            scan_row();
        end
        probe(44, 1'b0, "relost_idle");
        probe(24, 1'b1, "relost_slot0");

        // No lives left: lifeLost is ignored.
        livesIn = 4'd0;
        sof_pulse();
        lost_pulse();
        scan_row();
        probe(24, 1'b0, "dead_ignore");
        sof_pulse();
        scan_row();
        probe(24, 1'b0, "dead_next");

        // Asynchronous reset in the middle of a blink.
        livesIn = 4'd3;
        sof_pulse();
        lost_pulse();
        sof_pulse();
        sof_pulse();
        pixelX = 11'd24;
        pixelY = 11'd16;
        tick();
        tick();
        #2 resetN = 1'b0;
        #1 chk("rst_async", {heartDrawingRequest, heartRGB}, 9'h000);
        tick();
        tick();
        resetN = 1'b1;
        livesIn = 4'd2;
        scan_row();
        probe(24, 1'b0, "rst_no_hearts");
        sof_pulse();
        scan_row();
        probe(44, 1'b1, "rst_slot1");
        probe(64, 1'b0, "rst_idle_slot2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
